// File: rtl/cuenta_regresiva_seg.sv
// cuenta_regresiva_seg -- two-digit BCD countdown timer with alarm.
//
// Ports:
//   ClkRedu     in   count tick clock (slow 1 Hz); all state changes on its rising edge
//   reset       in   asynchronous, active-high reset
//   load        in   capture preset_dec/preset_uni (clamped to 9) and go IDLE
//   start       in   begin / resume the countdown
//   pause       in   freeze the countdown
//   preset_dec  in   [3:0] BCD tens digit of the preset
//   preset_uni  in   [3:0] BCD units digit of the preset
//   decenas     out  [3:0] BCD tens digit of the current count
//   unidades    out  [3:0] BCD units digit of the current count
//   running     out  high in RUN only
//   alarm       out  high in DONE only
//
// Parameter ALARM_TICKS (1..15): number of edges alarm stays high in DONE.
// Optional macro AUTO_RELOAD_EN: after DONE, reload the last loaded preset and
// run again (or go IDLE when that preset is 00). Without it no preset copy is
// kept and DONE always exits to IDLE.
// Input priority on each edge: load > pause > start.

module cuenta_regresiva_seg #(
    parameter int ALARM_TICKS = 5
) (
    input  logic       ClkRedu,
    input  logic       reset,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic [3:0] preset_dec,
    input  logic [3:0] preset_uni,
    output logic [3:0] decenas,
    output logic [3:0] unidades,
    output logic       running,
    output logic       alarm
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSA = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // DONE is left on the edge where the alarm counter has seen ALARM_TICKS-1
    // prior DONE edges, so alarm is high for exactly ALARM_TICKS edges.
    localparam logic [3:0] ALARM_LAST = 4'(ALARM_TICKS - 1);

    state_t     state_q, state_d;
    logic [3:0] dec_q, dec_d;
    logic [3:0] uni_q, uni_d;
    logic [3:0] acnt_q, acnt_d;
    logic       running_q, running_d;
    logic       alarm_q, alarm_d;
`ifdef AUTO_RELOAD_EN
    logic [7:0] preset_q, preset_d;
`endif

    function automatic logic [3:0] clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    always_comb begin
        state_d = state_q;
        dec_d   = dec_q;
        uni_d   = uni_q;
        acnt_d  = acnt_q;
`ifdef AUTO_RELOAD_EN
        preset_d = preset_q;
`endif
        if (load) begin
            dec_d   = clamp9(preset_dec);
            uni_d   = clamp9(preset_uni);
            acnt_d  = 4'd0;
            state_d = S_IDLE;
`ifdef AUTO_RELOAD_EN
            preset_d = {clamp9(preset_dec), clamp9(preset_uni)};
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (!pause && start && (dec_q != 4'd0 || uni_q != 4'd0))
                        state_d = S_RUN;
                end
                S_RUN: begin
                    if (pause) begin
                        state_d = S_PAUSA;
                    end else if (dec_q == 4'd0 && uni_q <= 4'd1) begin
                        // 01 -> 00 (00 is guarded too so the count never wraps)
                        uni_d   = 4'd0;
                        acnt_d  = 4'd0;
                        state_d = S_DONE;
                    end else if (uni_q != 4'd0) begin
                        uni_d = uni_q - 4'd1;
                    end else begin
                        uni_d = 4'd9;
                        dec_d = dec_q - 4'd1;
                    end
                end
                S_PAUSA: begin
                    if (!pause && start)
                        state_d = S_RUN;
                end
                S_DONE: begin
                    if (acnt_q >= ALARM_LAST) begin
                        acnt_d  = 4'd0;
                        state_d = S_IDLE;
`ifdef AUTO_RELOAD_EN
                        if (preset_q != 8'd0) begin
                            dec_d   = preset_q[7:4];
                            uni_d   = preset_q[3:0];
                            state_d = S_RUN;
                        end
`endif
                    end else begin
                        acnt_d = acnt_q + 4'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        // Outputs are registered copies of the next state decode.
        running_d = (state_d == S_RUN);
        alarm_d   = (state_d == S_DONE);
    end

    always_ff @(posedge ClkRedu or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            dec_q     <= 4'd0;
            uni_q     <= 4'd0;
            acnt_q    <= 4'd0;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            dec_q     <= dec_d;
            uni_q     <= uni_d;
            acnt_q    <= acnt_d;
            running_q <= running_d;
            alarm_q   <= alarm_d;
        end
    end

`ifdef AUTO_RELOAD_EN
    always_ff @(posedge ClkRedu or posedge reset) begin
        if (reset) preset_q <= 8'd0;
        else       preset_q <= preset_d;
    end
`endif

    assign decenas  = dec_q;
    assign unidades = uni_q;
    assign running  = running_q;
    assign alarm    = alarm_q;

endmodule

// File: tb/tb_cuenta_regresiva_seg.sv
module tb_cuenta_regresiva_seg;

    localparam int AT = 5;

    logic       ClkRedu = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0, start = 1'b0, pause = 1'b0;
    logic [3:0] preset_dec = 4'd0, preset_uni = 4'd0;
    logic [3:0] decenas, unidades;
    logic       running, alarm;

    int pass_cnt = 0;
    int total_cnt = 0;

    cuenta_regresiva_seg #(.ALARM_TICKS(AT)) dut (
        .ClkRedu(ClkRedu), .reset(reset), .load(load), .start(start), .pause(pause),
        .preset_dec(preset_dec), .preset_uni(preset_uni),
        .decenas(decenas), .unidades(unidades), .running(running), .alarm(alarm)
    );

    always #5 ClkRedu = ~ClkRedu;

    // Behavioural model: count as an integer 0..99, mode as a plain number
    // (0 idle, 1 counting, 2 paused, 3 alarm), alarm time remaining in edges.
    int m_cnt = 0, m_mode = 0, m_left = 0, m_preset = 0;

    function automatic int cl(input logic [3:0] d);
        return (d > 9) ? 9 : int'(d);
    endfunction

    initial forever begin
        @(posedge ClkRedu or posedge reset);
        if (reset) begin
            m_cnt = 0; m_mode = 0; m_left = 0; m_preset = 0;
        end else if (load) begin
            m_cnt = cl(preset_dec) * 10 + cl(preset_uni);
            m_preset = m_cnt;
            m_mode = 0;
        end else begin
            case (m_mode)
                0: if (!pause && start && m_cnt != 0) m_mode = 1;
                1: if (pause) m_mode = 2;
                   else begin
                       m_cnt = m_cnt - 1;
                       if (m_cnt == 0) begin m_mode = 3; m_left = AT; end
                   end
                2: if (!pause && start) m_mode = 1;
                default: begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_mode = 0;
`ifdef AUTO_RELOAD_EN
                        if (m_preset != 0) begin m_cnt = m_preset; m_mode = 1; end
`endif
                    end
                end
            endcase
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge ClkRedu);
        chk("model_dec", int'(decenas), m_cnt / 10);
        chk("model_uni", int'(unidades), m_cnt % 10);
        chk("model_running", int'(running), int'(m_mode == 1));
        chk("model_alarm", int'(alarm), int'(m_mode == 3));
    end

    // Apply inputs for one edge, return at the following negedge.
    task automatic drive(input logic l, s, p, input logic [3:0] d, u);
        load = l; start = s; pause = p; preset_dec = d; preset_uni = u;
        @(negedge ClkRedu);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
    endtask

    task automatic chk_out(input string name, input int c, input int r, input int a);
        chk({name, "_dec"}, int'(decenas), c / 10);
        chk({name, "_uni"}, int'(unidades), c % 10);
        chk({name, "_running"}, int'(running), r);
        chk({name, "_alarm"}, int'(alarm), a);
    endtask

    initial begin
        @(negedge ClkRedu);
        chk_out("reset", 0, 0, 0);
        reset = 1'b0;
        idle(1);

        // 12 down to 00, then AT alarm edges, then IDLE
        drive(1, 0, 0, 4'd1, 4'd2);  chk_out("load12", 12, 0, 0);
        drive(0, 1, 0, 4'd0, 4'd0);  chk_out("start12", 12, 1, 0);
        idle(1);                     chk_out("cnt11", 11, 1, 0);
        idle(2);                     chk_out("cnt09", 9, 1, 0);
        idle(9);                     chk_out("cnt00", 0, 0, 1);
        idle(AT - 1);                chk_out("alarm_last", 0, 0, 1);
        idle(1);                     chk_out("alarm_off", 0, 0, 0);

        // start at 00 is ignored
        drive(0, 1, 0, 4'd0, 4'd0);  chk_out("start00", 0, 0, 0);

        // clamp
        drive(1, 0, 0, 4'hC, 4'hF);  chk_out("clamp99", 99, 0, 0);
        drive(1, 0, 0, 4'd3, 4'hA);  chk_out("clamp39", 39, 0, 0);

        // pause / resume
        drive(1, 0, 0, 4'd0, 4'd5);
        drive(0, 1, 0, 4'd0, 4'd0);
        idle(2);                     chk_out("pre_pause", 3, 1, 0);
        drive(0, 0, 1, 4'd0, 4'd0);  chk_out("pause1", 3, 0, 0);
        drive(0, 1, 1, 4'd0, 4'd0);  chk_out("pause_wins", 3, 0, 0);
        drive(0, 1, 0, 4'd0, 4'd0);  chk_out("resume", 3, 1, 0);
        idle(1);                     chk_out("resume02", 2, 1, 0);
        idle(2);                     chk_out("resume00", 0, 0, 1);
        drive(0, 1, 1, 4'd0, 4'd0);  chk_out("done_ign", 0, 0, 1);
        idle(AT);                    chk_out("done_exit", 0, 0, 0);

        // asynchronous reset mid-RUN at 07
        drive(1, 0, 0, 4'd1, 4'd0);
        drive(0, 1, 0, 4'd0, 4'd0);
        idle(3);                     chk_out("at07", 7, 1, 0);
        #1 reset = 1'b1;
        #1 chk_out("async_rst", 0, 0, 0);
        #1 reset = 1'b0;
        @(negedge ClkRedu);
        drive(0, 1, 0, 4'd0, 4'd0);  chk_out("rst_start", 0, 0, 0);

        // load + start during RUN
        drive(1, 0, 0, 4'd3, 4'd0);
        drive(0, 1, 0, 4'd0, 4'd0);
        idle(2);                     chk_out("run28", 28, 1, 0);
        drive(1, 1, 0, 4'd4, 4'd5);  chk_out("load_start", 45, 0, 0);
        idle(1);                     chk_out("stay_idle", 45, 0, 0);

        // load aborts DONE
        drive(1, 0, 0, 4'd0, 4'd1);
        drive(0, 1, 0, 4'd0, 4'd0);
        idle(1);                     chk_out("done01", 0, 0, 1);
        drive(1, 0, 0, 4'd0, 4'd4);  chk_out("load_in_done", 4, 0, 0);

`ifdef AUTO_RELOAD_EN
        drive(1, 0, 0, 4'd0, 4'd2);
        drive(0, 1, 0, 4'd0, 4'd0);
        idle(2);                     chk_out("ar_done", 0, 0, 1);
        idle(AT);                    chk_out("ar_reload", 2, 1, 0);
        idle(1);                     chk_out("ar_01", 1, 1, 0);
        drive(1, 0, 0, 4'd0, 4'd0);
        idle(1);
`endif
        idle(2);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
